// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM encodings, result width, ALU codes.
// State encodings DIV_IDLE/DIV_BUSY/DIV_DONE live here in place of a defines header.
package div_unit_pkg;

  localparam int DIV_W        = 32;
  localparam int DIV_RESULT_W = 2 * DIV_W;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = DIV_IDLE,
    S_BUSY = DIV_BUSY,
    S_DONE = DIV_DONE
  } div_state_e;

  // ALU control codes that select this unit in the decoder
  localparam logic [7:0] ALUC_DIV  = 8'h1a;
  localparam logic [7:0] ALUC_DIVU = 8'h1b;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake: operands/control in, stall/ready/result out.
interface div_unit_if #(parameter int WIDTH = 32) ();

  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               annul_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, a_i, b_i, annul_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, annul_i,
    output stall_o, ready_o, result_o
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // One extra bit keeps the shifted remainder exact when dvs uses the top bit
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_comb begin
    rem_nxt = shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit; stalls E until the {HI=rem, LO=quo} result is ready.
// Optional DIV_EARLY_EXIT_EN: finish in two cycles when |a| < |b|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [CW-1:0]      count_q;
  logic               sign_q, sign_r;
  logic [2*WIDTH-1:0] result_q, fresh;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               load, load_zero, load_early, step, commit;

  assign a_neg = bus.signed_i & bus.a_i[WIDTH-1];
  assign b_neg = bus.signed_i & bus.b_i[WIDTH-1];
  assign a_mag = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag = b_neg ? -bus.b_i : bus.b_i;

  // Negation wraps naturally, so 0x80000000 / -1 yields 0x80000000
  assign fresh = {(sign_r ? -rem_q : rem_q), (sign_q ? -quo_q : quo_q)};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    load_zero    = 1'b0;
    load_early   = 1'b0;
    step         = 1'b0;
    commit       = 1'b0;
    bus.ready_o  = 1'b0;
    bus.result_o = result_q;
    bus.stall_o  = bus.start_i & ~bus.annul_i & (state_q != S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          state_d = S_DONE;
          if (bus.b_i == '0) begin
            load_zero = 1'b1;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (a_mag < b_mag) begin
            load_early = 1'b1;
          end
`endif
          else begin
            load    = 1'b1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // A dropped start without annul is illegal; abandon quietly
        if (bus.annul_i || !bus.start_i) begin
          state_d = S_IDLE;
        end else begin
          step = 1'b1;
          if (count_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!bus.annul_i) begin
          bus.ready_o  = 1'b1;
          bus.result_o = fresh;
          commit       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_q <= '0;
    end else begin
      if (load) begin
        rem_q   <= '0;
        quo_q   <= a_mag;
        dvs_q   <= b_mag;
        count_q <= CW'(WIDTH);
        sign_q  <= a_neg ^ b_neg;
        sign_r  <= a_neg;
      end
      // Short paths store the final HI/LO directly, so signs are cleared
      if (load_zero || load_early) begin
        rem_q  <= bus.a_i;
        quo_q  <= load_zero ? '1 : '0;
        sign_q <= 1'b0;
        sign_r <= 1'b0;
      end
      if (step) begin
        rem_q   <= rem_nxt;
        quo_q   <= quo_nxt;
        count_q <= count_q - CW'(1);
      end
      if (commit) result_q <= fresh;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, checked on ready_o.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] ma, mb;
    if (b == 0) return 1;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) return 1;
`endif
    if (ma == mb) return W + 1;
    return W + 1;
  endfunction

  always @(negedge clk) begin
    if (rst && bus.ready_o) begin
      if (exp_q.size() == 0) chk("spurious_ready", 64'd1, 64'd0);
      else begin
        last_exp = exp_q.pop_front();
        chk("result", bus.result_o, last_exp);
      end
    end
  end

  // Issues one divide and follows it to ready; leaves start low afterwards
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    int lat, stalls;
    bit seen;
    exp_q.push_back(model(a, b, sgn));
    lat          = exp_lat(a, b, sgn);
    bus.start_i  = 1'b1;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.signed_i = sgn;
    stalls = 0;
    seen   = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.stall_o) stalls++;
      if (bus.ready_o) begin
        seen = 1'b1;
        chk({tag, "_lat"}, 64'(c), 64'(lat));
      end
      @(posedge clk); #1;
    end
    if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
    chk({tag, "_stalls"}, 64'(stalls), 64'(lat));
    bus.start_i = 1'b0;
  endtask

  task automatic annul_at(input logic [31:0] a, input logic [31:0] b, input int k, input string tag);
    bus.start_i  = 1'b1;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.signed_i = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    bus.annul_i = 1'b1;
    @(negedge clk);
    chk({tag, "_stall"}, 64'(bus.stall_o), 64'd0);
    chk({tag, "_ready"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_res"}, bus.result_o, last_exp);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_hold"}, bus.result_o, last_exp);
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.annul_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    rst = 1'b1;

    do_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    do_div(-32'sd7, 32'd2, 1'b1, "div_m7_2");
    do_div(32'd7, 32'd0, 1'b1, "div_7_0");

    annul_at(32'd1000, 32'd3, 10, "annul_busy");
    do_div(32'd9, 32'd3, 1'b0, "divu_9_3");
    annul_at(32'd50, 32'd5, 33, "annul_done");

    do_div(32'd1234567, 32'd89, 1'b0, "b2b_0");
    do_div(32'hFFFF_FFFF, 32'h0001_0000, 1'b0, "b2b_1");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    do_div(32'h8000_0000, 32'h8000_0000, 1'b0, "divu_msb");
    do_div(32'd3, 32'd10, 1'b0, "divu_3_10");

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 30);
      do_div(ra, rb, 1'(i), "rand");
    end

    bus.start_i  = 1'b1;
    bus.a_i      = 32'd12345;
    bus.b_i      = 32'd11;
    bus.signed_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst         = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    chk("midrst_stall", 64'(bus.stall_o), 64'd0);
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);
    rst      = 1'b1;
    last_exp = '0;
    do_div(32'd77, 32'd8, 1'b1, "after_rst");

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
